// File: rtl/msm_rd_arb_pkg.sv
// msm_rd_arb_pkg: shared types, constants and helpers for the MSM AXI read arbiter.
//   REQ_IDX_W / OST_W : index and occupancy widths for the default 4-requester, 16-deep build
//   AXI_RESP_OKAY     : RRESP value treated as success
//   axsize()          : AXI AxSIZE encoding for a given data-bus width
//   ar_req_t          : latched AR burst (address, length)
//   ar_state_e        : AR output-slice states
package msm_rd_arb_pkg;

  localparam int unsigned NUM_REQ_DFLT  = 4;
  localparam int unsigned MAX_OST_DFLT  = 16;
  localparam int unsigned REQ_IDX_W     = $clog2(NUM_REQ_DFLT);
  localparam int unsigned OST_W         = $clog2(MAX_OST_DFLT) + 1;
  localparam int unsigned AR_ADDR_MAX_W = 64;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [2:0] axsize(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  typedef struct packed {
    logic [AR_ADDR_MAX_W-1:0] addr;
    logic [7:0]               len;
  } ar_req_t;

  typedef enum logic {
    AR_IDLE,
    AR_ISSUE
  } ar_state_e;

endpackage

// File: rtl/msm_rd_order_fifo.sv
// msm_rd_order_fifo: synchronous FIFO recording the requester index of each issued AR burst,
// so R beats can be routed back in issue order.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write one index
//   pop        : discard the head entry
//   full/empty : occupancy flags
//   head       : oldest entry (valid when !empty)
//   count      : current occupancy, 0..DEPTH
module msm_rd_order_fifo
  import msm_rd_arb_pkg::*;
#(
  parameter int unsigned W     = REQ_IDX_W,
  parameter int unsigned DEPTH = 2 ** (OST_W - 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/msm_axi_rd_arbiter.sv
// msm_axi_rd_arbiter: shares the MSM kernel's AXI master read channel (AR/R) among NUM_REQ
// requesters. AR bursts are granted round-robin through a registered output slice; R beats are
// routed back in issue order via msm_rd_order_fifo.
//   ap_clk, ap_rst                  : clock, synchronous active-high reset
//   req_ar{valid,ready,addr,len}    : per-requester AR requests (addr/len packed by index)
//   req_r{valid,ready}, req_r{data,last} : per-requester R handshake, shared data/last
//   m_ar*, m_r*                     : AXI master AR/R channel
//   outstanding                     : bursts issued and not yet completed
//   err_valid/err_req/err_resp/err_clr : first-RRESP-error capture
// Build option: define MSM_RD_RRESP_CAPTURE_EN to build the RRESP error capture; otherwise
// err_* are tied to zero and err_clr is ignored.
module msm_axi_rd_arbiter
  import msm_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic [NUM_REQ-1:0]                 req_arvalid,
  output logic [NUM_REQ-1:0]                 req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]          req_araddr,
  input  logic [NUM_REQ*8-1:0]               req_arlen,
  output logic [NUM_REQ-1:0]                 req_rvalid,
  input  logic [NUM_REQ-1:0]                 req_rready,
  output logic [DATA_W-1:0]                  req_rdata,
  output logic                               req_rlast,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  output logic [ADDR_W-1:0]                  m_araddr,
  output logic [7:0]                         m_arlen,
  output logic [2:0]                         m_arsize,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic                               m_rlast,
  input  logic [1:0]                         m_rresp,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_valid,
  output logic [$clog2(NUM_REQ)-1:0]         err_req,
  output logic [1:0]                         err_resp,
  input  logic                               err_clr
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  ar_state_e        state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  ar_req_t          ar_q, ar_d;

  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0] head;

  // First requester at or after the RR pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_arvalid[IDX_W'((32'(rr_q) + k) % NUM_REQ)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'((32'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    ar_d        = ar_q;
    req_arready = '0;
    fifo_push   = 1'b0;
    case (state_q)
      AR_IDLE: begin
        // The ap_rst gate keeps req_arready low while the block is held in reset.
        if (!ap_rst && gnt_found && !fifo_full) begin
          req_arready[gnt_idx] = 1'b1;
          gnt_d                = gnt_idx;
          ar_d.addr            = AR_ADDR_MAX_W'(req_araddr[gnt_idx*ADDR_W +: ADDR_W]);
          ar_d.len             = req_arlen[gnt_idx*8 +: 8];
          state_d              = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (m_arready) begin
          fifo_push = 1'b1;
          rr_d      = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + IDX_W'(1);
          state_d   = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= AR_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ar_q    <= ar_d;
    end
  end

  assign m_arvalid = (state_q == AR_ISSUE);
  assign m_araddr  = ar_q.addr[ADDR_W-1:0];
  assign m_arlen   = ar_q.len;
  assign m_arsize  = axsize(DATA_W);

  msm_rd_order_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (fifo_push),
    .push_data (gnt_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .count     (outstanding)
  );

  // R beats always belong to the oldest outstanding burst.
  always_comb begin
    req_rvalid = '0;
    if (m_rvalid && !fifo_empty) begin
      req_rvalid[head] = 1'b1;
    end
  end

  assign m_rready  = !fifo_empty && req_rready[head];
  assign fifo_pop  = m_rvalid && m_rready && m_rlast;
  assign req_rdata = m_rdata;
  assign req_rlast = m_rlast;

  // A beat with nothing outstanding has no owner and stalls forever.
  a_no_orphan_beat: assert property (@(posedge ap_clk) disable iff (ap_rst)
    !(m_rvalid && fifo_empty));

`ifdef MSM_RD_RRESP_CAPTURE_EN
  logic             err_valid_q, err_valid_d;
  logic [IDX_W-1:0] err_req_q, err_req_d;
  logic [1:0]       err_resp_q, err_resp_d;

  always_comb begin
    err_valid_d = err_valid_q;
    err_req_d   = err_req_q;
    err_resp_d  = err_resp_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_req_d   = '0;
      err_resp_d  = '0;
    end else if (!err_valid_q && m_rvalid && m_rready && (m_rresp != AXI_RESP_OKAY)) begin
      err_valid_d = 1'b1;
      err_req_d   = head;
      err_resp_d  = m_rresp;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err_valid_q <= 1'b0;
      err_req_q   <= '0;
      err_resp_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_req_q   <= err_req_d;
      err_resp_q  <= err_resp_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_req   = err_req_q;
  assign err_resp  = err_resp_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{err_clr, m_rresp};

  assign err_valid = 1'b0;
  assign err_req   = '0;
  assign err_resp  = '0;
`endif

endmodule
